// File: rtl/dmem_uart_bridge.sv
// Generic synchronous FIFO: circular buffer with occupancy count, head visible combinationally.
// Latency: a pushed entry is visible at the head one clock after the push edge.
// Backpressure: pushes while full are ignored, pops while empty are ignored; caller watches full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage array: written only on an accepted push, never cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Data-memory stage: word RAM plus a memory-mapped 8N1 UART transmitter fed by a FIFO.
// Latency: RAM/status reads are combinational; a byte pushed into an idle UART starts its start bit one clock later.
// Backpressure: none toward the datapath; TXDATA writes into a full FIFO are dropped and latch a sticky overflow flag.
module dmem_uart_bridge #(
    parameter int RAM_WORDS    = 256,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        uart_tx
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [31:0] TXDATA    = 32'h0000_0400;
    localparam logic [31:0] TXSTAT    = 32'h0000_0404;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic          ram_sel;
    logic [AW-1:0] ram_idx;
    logic          tx_push;
    logic          stat_wr;
    logic          overflow;

    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_q, tx_n;
    logic          baud_end;
    logic          busy;

    // Address decode: RAM occupies the low window, everything above is register space or unmapped.
    assign ram_sel  = (Mem_WrAddr[31:AW+2] == '0);
    assign ram_idx  = Mem_WrAddr[AW+1:2];
    assign tx_push  = MemWrite && (Mem_WrAddr == TXDATA);
    assign stat_wr  = MemWrite && (Mem_WrAddr == TXSTAT);
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign busy     = (state != IDLE);
    assign uart_tx  = tx_q;

    // Whole-word RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) begin
            ram[ram_idx] <= Mem_WrData;
        end
    end

    // Combinational read mux: RAM word, status register, or zero.
    always_comb begin
        ReadData = '0;
        if (ram_sel) begin
            ReadData = ram[ram_idx];
        end else if (Mem_WrAddr == TXSTAT) begin
            ReadData = {16'd0, 8'(fifo_count), 4'd0, overflow, busy, fifo_empty, fifo_full};
        end
    end

    // Sticky overflow: set when a byte is dropped on a full FIFO, cleared by any status write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (stat_wr) begin
            overflow <= 1'b0;
        end else if (tx_push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_push),
        .push_dat (Mem_WrData[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Serializer state register; line output is registered from the next state so it never glitches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
        end
    end

    // Serializer next-state: the baud counter restarts on every state entry; STOP chains straight into the next frame.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        fifo_pop = 1'b0;
        tx_n     = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_head;
                    bit_n    = '0;
                    baud_n   = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_n  = fifo_head;
                        bit_n    = '0;
                        state_n  = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[bit_n];
            default: tx_n = 1'b1;
        endcase
    end
endmodule
